// File: rtl/mega_logic_serial.sv
// Byte-serial wide bitwise logic unit: latches A/B/op on start, then streams
// f(A,B) out one LANE-wide beat per valid/ready handshake, lowest lane first.
module mega_logic_serial #(
  parameter int WIDTH = 64,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             busy,
  output logic [LANE-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  localparam int NUM_LANES = WIDTH / LANE;
  localparam int IW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                           state;
  logic [NUM_LANES-1:0][LANE-1:0]   a_r;
  logic [NUM_LANES-1:0][LANE-1:0]   b_r;
  logic [1:0]                       op_r;
  logic [IW-1:0]                    idx;
  logic [IW-1:0]                    next_idx;

  assign next_idx = idx + IW'(1);

  function automatic logic [LANE-1:0] lane_op(input logic [LANE-1:0] a,
                                              input logic [LANE-1:0] b,
                                              input logic [1:0]      sel);
    logic [LANE-1:0] r;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  // out_data is precomputed one step ahead so every output stays a pure register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 2'b00;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r       <= A;
            b_r       <= B;
            op_r      <= op;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= lane_op(A[LANE-1:0], B[LANE-1:0], op);
            out_last  <= (NUM_LANES == 1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              idx       <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx      <= next_idx;
              out_data <= lane_op(a_r[next_idx], b_r[next_idx], op_r);
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
